// File: rtl/pc_sequencer.sv
// -----------------------------------------------------------------------------
// pc_sequencer
//
// Program-counter sequencer. It steps the PC, takes jumps through a 16-entry
// target LUT, and optionally supports call/return through a return-address
// stack. Every taken redirect is followed by exactly one FLUSH bubble.
// An illegal stack operation parks the block in HALT until reset.
//
// Configuration macro: PC_SEQ_RAS_EN
//   defined   - CALL pushes PC+1 and ret pops it (return-address stack).
//   undefined - CALL behaves as JMP, ret behaves as SEQ,
//               ras_level is tied to 0 and stack_err is tied to 0.
//
// Parameters:
//   D          program-counter width in bits (>= 4)
//   RAS_DEPTH  return-address stack entries (power of 2, 2..8)
//
// Ports:
//   clk        clock; all state updates on the rising edge
//   reset      synchronous active-low reset
//   stall      freezes PC, stack and FSM; LUT writes still proceed
//   op         00 SEQ, 01 JMP, 10 BRF (branch if flag), 11 CALL
//   ret        return request; has priority over op
//   flag       branch condition for BRF
//   lut_idx    target-LUT index for JMP/BRF/CALL
//   lut_we     target-LUT write enable
//   lut_waddr  target-LUT write address
//   lut_wdata  target-LUT write data
//   prog_ctr   registered program counter
//   redirect   one-cycle pulse after a taken jump/call/return
//   busy       FSM is not in RUN
//   stack_err  sticky stack overflow/underflow flag
//   ras_level  current stack occupancy
// -----------------------------------------------------------------------------
module pc_sequencer #(
  parameter int D         = 10,
  parameter int RAS_DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         stall,
  input  logic [1:0]   op,
  input  logic         ret,
  input  logic         flag,
  input  logic [3:0]   lut_idx,
  input  logic         lut_we,
  input  logic [3:0]   lut_waddr,
  input  logic [D-1:0] lut_wdata,
  output logic [D-1:0] prog_ctr,
  output logic         redirect,
  output logic         busy,
  output logic         stack_err,
  output logic [3:0]   ras_level
);

  // Elaboration-time parameter sanity checks.
  if (D < 4) begin : g_bad_width
    $error("pc_sequencer: D must be at least 4");
  end
  if (RAS_DEPTH < 2 || RAS_DEPTH > 8 || (RAS_DEPTH & (RAS_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("pc_sequencer: RAS_DEPTH must be a power of 2 in 2..8");
  end

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_FLUSH = 2'd1,
    ST_HALT  = 2'd2
  } state_e;

  localparam logic [1:0] OP_SEQ  = 2'b00;
  localparam logic [1:0] OP_JMP  = 2'b01;
  localparam logic [1:0] OP_BRF  = 2'b10;
  localparam logic [1:0] OP_CALL = 2'b11;

  state_e       state_q, state_d;
  logic [D-1:0] pc_q, pc_d;
  logic         redirect_q, redirect_d;
  logic [D-1:0] lut_q [16];
  logic [D-1:0] pc_inc;
  logic [D-1:0] lut_rd;

  // Natural D-bit overflow gives the all-ones -> 0 wrap.
  assign pc_inc = pc_q + D'(1);
  // Combinational read of the registered LUT. A same-cycle write lands at
  // the edge, so the read still sees the old entry.
  assign lut_rd = lut_q[lut_idx];

`ifdef PC_SEQ_RAS_EN
  localparam int         RAS_AW   = $clog2(RAS_DEPTH);
  localparam logic [3:0] RAS_FULL = 4'(RAS_DEPTH);

  logic [D-1:0]      ras_q [RAS_DEPTH];
  logic [3:0]        lvl_q, lvl_d;
  logic              err_q, err_d;
  logic              push;
  logic [RAS_AW-1:0] push_idx;
  logic [RAS_AW-1:0] top_idx;

  // The stack grows upward: the next free slot is at lvl, and the top is at lvl-1.
  assign push_idx = RAS_AW'(lvl_q);
  assign top_idx  = RAS_AW'(lvl_q - 4'd1);
`endif

  // ---------------------------------------------------------------------------
  // Next-state / next-PC decode
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    redirect_d = 1'b0;
`ifdef PC_SEQ_RAS_EN
    lvl_d      = lvl_q;
    err_d      = err_q;
    push       = 1'b0;
`endif

    unique case (state_q)
      ST_RUN: begin
        if (!stall) begin
          if (ret) begin
`ifdef PC_SEQ_RAS_EN
            if (lvl_q != 4'd0) begin
              pc_d       = ras_q[top_idx];
              lvl_d      = lvl_q - 4'd1;
              redirect_d = 1'b1;
              state_d    = ST_FLUSH;
            end else begin
              // Underflow: keep the PC and stack as they are, and park.
              err_d   = 1'b1;
              state_d = ST_HALT;
            end
`else
            pc_d = pc_inc;
`endif
          end else begin
            case (op)
              OP_SEQ: pc_d = pc_inc;
              OP_JMP: begin
                pc_d       = lut_rd;
                redirect_d = 1'b1;
                state_d    = ST_FLUSH;
              end
              OP_BRF: begin
                if (flag) begin
                  pc_d       = lut_rd;
                  redirect_d = 1'b1;
                  state_d    = ST_FLUSH;
                end else begin
                  pc_d = pc_inc;
                end
              end
              OP_CALL: begin
`ifdef PC_SEQ_RAS_EN
                if (lvl_q < RAS_FULL) begin
                  push       = 1'b1;
                  lvl_d      = lvl_q + 4'd1;
                  pc_d       = lut_rd;
                  redirect_d = 1'b1;
                  state_d    = ST_FLUSH;
                end else begin
                  // Overflow: keep the PC and stack as they are, and park.
                  err_d   = 1'b1;
                  state_d = ST_HALT;
                end
`else
                pc_d       = lut_rd;
                redirect_d = 1'b1;
                state_d    = ST_FLUSH;
`endif
              end
              default: pc_d = pc_q;
            endcase
          end
        end
      end

      // A single bubble after a redirect. A stall stretches it.
      ST_FLUSH: begin
        if (!stall) begin
          state_d = ST_RUN;
        end
      end

      // Only reset leaves HALT.
      ST_HALT: state_d = ST_HALT;

      default: state_d = ST_RUN;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Control state registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= ST_RUN;
      pc_q       <= '0;
      redirect_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      redirect_q <= redirect_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Jump-target LUT: reset spreads the targets evenly across the address space
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < 16; i++) begin
        lut_q[i] <= D'(i) << (D - 4);
      end
    end else if (lut_we) begin
      lut_q[lut_waddr] <= lut_wdata;
    end
  end

`ifdef PC_SEQ_RAS_EN
  // ---------------------------------------------------------------------------
  // Return-address stack (the contents are not reset; only the level is)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset) begin
      lvl_q <= 4'd0;
      err_q <= 1'b0;
    end else begin
      lvl_q <= lvl_d;
      err_q <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset && push) begin
      ras_q[push_idx] <= pc_inc;
    end
  end

  assign ras_level = lvl_q;
  assign stack_err = err_q;
`else
  assign ras_level = 4'd0;
  assign stack_err = 1'b0;
`endif

  assign prog_ctr = pc_q;
  assign redirect = redirect_q;
  assign busy     = (state_q != ST_RUN);

endmodule

// File: tb/tb_pc_sequencer.sv
// -----------------------------------------------------------------------------
// tb_pc_sequencer
//
// Self-checking bench for pc_sequencer. A behavioural model (an integer PC,
// a queue for the return stack, and an integer array for the LUT) predicts
// every output after each clock edge. Directed scenarios are followed by a
// randomized run. Honours PC_SEQ_RAS_EN the same way the design does.
// -----------------------------------------------------------------------------
module tb_pc_sequencer;

  localparam int D         = 10;
  localparam int RAS_DEPTH = 4;
  localparam int PC_MOD    = 1 << D;

  localparam int M_RUN   = 0;
  localparam int M_FLUSH = 1;
  localparam int M_HALT  = 2;

  localparam logic [1:0] SEQ  = 2'b00;
  localparam logic [1:0] JMP  = 2'b01;
  localparam logic [1:0] BRF  = 2'b10;
  localparam logic [1:0] CALL = 2'b11;

  logic         clk = 1'b0;
  logic         reset;
  logic         stall;
  logic [1:0]   op;
  logic         ret;
  logic         flag;
  logic [3:0]   lut_idx;
  logic         lut_we;
  logic [3:0]   lut_waddr;
  logic [D-1:0] lut_wdata;
  logic [D-1:0] prog_ctr;
  logic         redirect;
  logic         busy;
  logic         stack_err;
  logic [3:0]   ras_level;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  int m_pc;
  int m_mode;
  int m_redirect;
  int m_err;
  int m_lut [16];
  int m_stack [$];

  pc_sequencer #(.D(D), .RAS_DEPTH(RAS_DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .stall     (stall),
    .op        (op),
    .ret       (ret),
    .flag      (flag),
    .lut_idx   (lut_idx),
    .lut_we    (lut_we),
    .lut_waddr (lut_waddr),
    .lut_wdata (lut_wdata),
    .prog_ctr  (prog_ctr),
    .redirect  (redirect),
    .busy      (busy),
    .stack_err (stack_err),
    .ras_level (ras_level)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_jump(input int tgt);
    m_pc       = tgt;
    m_redirect = 1;
    m_mode     = M_FLUSH;
  endtask

  task automatic model_halt();
    m_err  = 1;
    m_mode = M_HALT;
  endtask

  // Applies the rules for one rising edge, using the inputs applied at that edge.
  task automatic model_edge();
    int tgt;
    int nxt;
    if (!reset) begin
      m_pc       = 0;
      m_mode     = M_RUN;
      m_redirect = 0;
      m_err      = 0;
      m_stack.delete();
      for (int i = 0; i < 16; i++) m_lut[i] = (i << (D - 4)) % PC_MOD;
      return;
    end
    tgt = m_lut[lut_idx];          // read before the write lands
    nxt = (m_pc + 1) % PC_MOD;
    if (lut_we) m_lut[lut_waddr] = int'(lut_wdata);
    m_redirect = 0;
    if (m_mode == M_HALT || stall) return;
    if (m_mode == M_FLUSH) begin
      m_mode = M_RUN;
      return;
    end
    if (ret) begin
`ifdef PC_SEQ_RAS_EN
      if (m_stack.size() > 0) model_jump(m_stack.pop_back());
      else model_halt();
`else
      m_pc = nxt;
`endif
      return;
    end
    case (op)
      SEQ: m_pc = nxt;
      JMP: model_jump(tgt);
      BRF: if (flag) model_jump(tgt); else m_pc = nxt;
      default: begin
`ifdef PC_SEQ_RAS_EN
        if (m_stack.size() < RAS_DEPTH) begin
          m_stack.push_back(nxt);
          model_jump(tgt);
        end else begin
          model_halt();
        end
`else
        model_jump(tgt);
`endif
      end
    endcase
  endtask

  // One clock: the model advances at the edge, and the outputs are compared 1 ns later.
  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    chk("prog_ctr",  32'(prog_ctr),  32'(m_pc));
    chk("redirect",  32'(redirect),  32'(m_redirect));
    chk("busy",      32'(busy),      32'(m_mode != M_RUN));
    chk("stack_err", 32'(stack_err), 32'(m_err));
    chk("ras_level", 32'(ras_level), 32'(m_stack.size()));
    lut_we = 1'b0;
  endtask

  task automatic cyc(input logic [1:0] o, input logic [3:0] idx,
                     input logic f = 1'b0, input logic r = 1'b0, input logic st = 1'b0);
    reset   = 1'b1;
    op      = o;
    lut_idx = idx;
    flag    = f;
    ret     = r;
    stall   = st;
    tick();
  endtask

  task automatic lutw(input logic [3:0] a, input logic [D-1:0] v);
    lut_we    = 1'b1;
    lut_waddr = a;
    lut_wdata = v;
  endtask

  task automatic do_reset(input int n);
    reset = 1'b0;
    for (int i = 0; i < n; i++) tick();
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0; stall = 1'b0; op = SEQ; ret = 1'b0; flag = 1'b0;
    lut_idx = '0; lut_we = 1'b0; lut_waddr = '0; lut_wdata = '0;
    m_pc = 0; m_mode = M_RUN; m_redirect = 0; m_err = 0;
    for (int i = 0; i < 16; i++) m_lut[i] = 0;

    // Reset, then three sequential steps
    do_reset(2);
    chk("rst_pc", 32'(prog_ctr), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    for (int i = 0; i < 3; i++) begin
      cyc(SEQ, 4'd0);
      chk("seq_pc", 32'(prog_ctr), 32'(i + 1));
    end

    // Jump through a written LUT entry
    lutw(4'd5, 10'h155);
    cyc(SEQ, 4'd0);                       // pc 4
    cyc(JMP, 4'd5);
    chk("jmp_pc", 32'(prog_ctr), 32'h155);
    chk("jmp_redirect", 32'(redirect), 32'h1);
    chk("jmp_busy", 32'(busy), 32'h1);
    cyc(SEQ, 4'd0);                       // bubble
    chk("flush_pc", 32'(prog_ctr), 32'h155);
    chk("flush_redirect", 32'(redirect), 32'h0);
    cyc(SEQ, 4'd0);
    chk("post_jmp_pc", 32'(prog_ctr), 32'h156);

    // Conditional branch, not taken and then taken
    cyc(BRF, 4'd2, 1'b0);
    chk("brf0_pc", 32'(prog_ctr), 32'h157);
    cyc(BRF, 4'd2, 1'b1);
    chk("brf1_pc", 32'(prog_ctr), 32'h080);
    cyc(SEQ, 4'd0);

    // Call from 0x010 and then return
    lutw(4'd1, 10'h010);
    cyc(SEQ, 4'd0);
    cyc(JMP, 4'd1);
    cyc(SEQ, 4'd0);
    cyc(CALL, 4'd3);
    chk("call_pc", 32'(prog_ctr), 32'h0C0);
    cyc(SEQ, 4'd0);
    cyc(SEQ, 4'd0);
    cyc(JMP, 4'd0, 1'b0, 1'b1);           // ret wins over op
`ifdef PC_SEQ_RAS_EN
    chk("ret_pc", 32'(prog_ctr), 32'h011);
`else
    chk("ret_as_seq_pc", 32'(prog_ctr), 32'h0C2);
`endif
    cyc(SEQ, 4'd0);

    // A write and a read to the same index in one cycle return the old value
    lutw(4'd6, 10'h2AA);
    cyc(JMP, 4'd6);
    chk("wr_rd_old", 32'(prog_ctr), 32'h180);
    cyc(SEQ, 4'd0);
    cyc(JMP, 4'd6);
    chk("wr_rd_new", 32'(prog_ctr), 32'h2AA);
    cyc(SEQ, 4'd0);

    // PC wrap from all-ones
    lutw(4'd4, 10'h3FF);
    cyc(SEQ, 4'd0);
    cyc(JMP, 4'd4);
    cyc(SEQ, 4'd0);
    cyc(SEQ, 4'd0);
    chk("wrap_pc", 32'(prog_ctr), 32'h000);

    // Stall stretches the flush bubble
    cyc(JMP, 4'd5);
    for (int i = 0; i < 2; i++) begin
      cyc(SEQ, 4'd0, 1'b0, 1'b0, 1'b1);
      chk("stall_pc", 32'(prog_ctr), 32'h155);
      chk("stall_busy", 32'(busy), 32'h1);
    end
    cyc(SEQ, 4'd0);
    chk("flush_exit_busy", 32'(busy), 32'h0);
    cyc(SEQ, 4'd0);
    chk("post_stall_pc", 32'(prog_ctr), 32'h156);

    // Five calls: the fifth overflows a 4-deep stack
    for (int k = 0; k < 5; k++) begin
      cyc(CALL, 4'd3);
      cyc(SEQ, 4'd0);
    end
`ifdef PC_SEQ_RAS_EN
    chk("ovf_err", 32'(stack_err), 32'h1);
    chk("ovf_busy", 32'(busy), 32'h1);
    chk("ovf_pc", 32'(prog_ctr), 32'h0C0);
    chk("ovf_level", 32'(ras_level), 32'h4);
`endif
    for (int i = 0; i < 3; i++) cyc(JMP, 4'd5);
    do_reset(1);
    chk("rst2_pc", 32'(prog_ctr), 32'h0);
    chk("rst2_err", 32'(stack_err), 32'h0);

    // Randomized run
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 63) == 0) begin
        reset = 1'b0;
      end else begin
        reset = 1'b1;
      end
      stall   = ($urandom_range(0, 3) == 0);
      op      = 2'($urandom_range(0, 3));
      ret     = ($urandom_range(0, 7) == 0);
      flag    = 1'($urandom);
      lut_idx = 4'($urandom);
      if ($urandom_range(0, 3) == 0) lutw(4'($urandom), D'($urandom));
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 SHALL have parameter D, default 10, meaning the program-counter width in bits.
REQ-002 SHALL have parameter RAS_DEPTH, default 4, meaning the number of return-address stack entries (power of 2, 2..8).
REQ-003 SHALL have port clk, input, 1, meaning the single clock; all state updates on posedge clk.
REQ-004 SHALL have port reset, input, 1, meaning the reset; it is synchronous and active-low.
REQ-005 SHALL have port stall, input, 1, meaning hold: the PC, stack and FSM freeze (LUT writes still proceed).
REQ-006 SHALL have port op, input, 2, meaning the control op: 00 SEQ, 01 JMP, 10 BRF (branch if flag), 11 CALL.
REQ-007 SHALL have port ret, input, 1, meaning a return request; it has priority over op.
REQ-008 SHALL have port flag, input, 1, meaning the branch condition for BRF.
REQ-009 SHALL have port lut_idx, input, 4, meaning the jump-target LUT index for JMP/BRF/CALL.
REQ-010 SHALL have ports lut_we (1b), lut_waddr (4b) and lut_wdata (D bits), all inputs, meaning the target-LUT configuration write port.
REQ-011 SHALL have port prog_ctr, output, D bits, meaning the registered program counter.
REQ-012 SHALL have port redirect, output, 1, meaning a registered pulse on the cycle after a taken jump/call/return.
REQ-013 SHALL have port busy, output, 1, meaning the FSM is not in RUN.
REQ-014 SHALL have port stack_err, output, 1, meaning a sticky stack overflow/underflow flag.
REQ-015 SHALL have port ras_level, output, 4 bits, meaning the current stack occupancy.

Function
REQ-016 SHALL implement a 3-state FSM (RUN, FLUSH, HALT) with busy = (state != RUN).
REQ-017 SHALL accept ret/op only in RUN with stall=0; otherwise those inputs are ignored.
REQ-018 SHALL, on SEQ or untaken BRF, load prog_ctr <= prog_ctr+1 mod 2^D (all-ones wraps to 0), with no redirect and staying in RUN.
REQ-019 SHALL, on JMP or taken BRF, load prog_ctr <= lut[lut_idx], assert redirect the next cycle, and enter FLUSH.
REQ-020 SHALL, on CALL with ras_level < RAS_DEPTH, push prog_ctr+1 (wrapped), increment ras_level, then behave as JMP.
REQ-021 SHALL, on ret with ras_level > 0, pop the top entry into prog_ctr, decrement ras_level, assert redirect, and enter FLUSH.
REQ-022 SHALL, in FLUSH, hold prog_ctr for exactly one cycle (one bubble) and then return to RUN; stall in FLUSH extends FLUSH.
REQ-023 SHALL treat CALL with a full stack, or ret with an empty stack, as an error: set stack_err, leave prog_ctr and the stack unchanged, and enter HALT.
REQ-024 SHALL keep HALT, with prog_ctr frozen and all requests ignored, until reset.
REQ-025 SHALL make a LUT read in the same cycle as a write to the same index return the old value (write takes effect at the edge).
REQ-026 SHALL register redirect as a one-cycle pulse; it never asserts while in HALT.

Reset
REQ-027 SHALL, while reset==0 at a posedge, set prog_ctr=0, state=RUN, redirect=0, stack_err=0 and ras_level=0.
REQ-028 SHALL, on reset, load lut[i] = i << (D-4) for i=0..15; stack contents are don't-care.
REQ-029 SHALL give reset priority over stall, lut_we and all other inputs, including mid-FLUSH and in HALT.

Configuration
REQ-030 SHALL, with PC_SEQ_RAS_EN defined, implement the return-address stack as specified.
REQ-031 SHALL, without PC_SEQ_RAS_EN, decode CALL as JMP (no push), decode ret as SEQ, tie ras_level=0, and raise stack_err only never (tied 0).

Verification
REQ-032 SHALL cover: reset, then 3 SEQ cycles -> prog_ctr 0,1,2,3; redirect=0; busy=0.
REQ-033 SHALL cover: D=10, write lut[5]=0x155, then JMP idx 5 -> next prog_ctr=0x155, redirect=1 for one cycle, busy=1 for one cycle, then prog_ctr=0x156.
REQ-034 SHALL cover: BRF idx 2 with flag=0 -> prog_ctr+1; with flag=1 -> prog_ctr=0x080 (reset LUT value).
REQ-035 SHALL cover: at prog_ctr=0x010, CALL idx 3 -> prog_ctr=0x0C0, ras_level=1; later ret -> prog_ctr=0x011, ras_level=0.
REQ-036 SHALL cover: 5 CALLs with RAS_DEPTH=4 -> 5th sets stack_err=1, HALT, prog_ctr frozen; reset low -> prog_ctr=0, stack_err=0.
REQ-037 SHALL cover: prog_ctr=0x3FF with SEQ -> 0x000; stall=1 for 2 cycles during FLUSH -> prog_ctr unchanged, FLUSH exits 1 cycle after stall drops.
